imem_fetch_arbiter: RTL and testbench
=====================================

# imem_fetch_arbiter

Owns the single port of the 64-word instruction memory and shares it between the pipeline fetch stage and a program loader (debug/UART side). It sequences the core through load, run and halt phases, registers the fetched instruction, and stops fetch when a fence-family or ecall/ebreak instruction is fetched. It sits between the IF stage and the instruction memory and drives that memory's word address, write enable and write data.

## Interface
- N, 32, instruction/data width
- AW, 6, memory word-address width (depth 2^AW = 64)
- STARVE_MAX, 8, RUN-state loader wait cycles before a forced loader grant

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  pulse: LOAD/HALT -> RUN
- stop  in  1  pulse: RUN -> HALT
- fetch_req  in  1  fetch stage requests an instruction
- fetch_pc  in  32  byte PC; word address = fetch_pc[AW+1:2]
- fetch_flush  in  1  discard the word captured this cycle
- fetch_gnt  out  1  fetch owns memory this cycle
- fetch_valid  out  1  fetch_inst holds a valid word
- fetch_inst  out  N  registered instruction
- ld_req  in  1  loader request
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  AW  loader word address
- ld_wdata  in  N  loader write data
- ld_gnt  out  1  loader access performed this cycle
- ld_rdata  out  N  registered loader read data
- ld_err  out  1  one-cycle pulse: write rejected in RUN
- mem_addr  out  AW  memory word address
- mem_we  out  1  memory write enable
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, combinational from mem_addr
- state  out  2  00 LOAD, 01 RUN, 10 HALT
- halt_cause  out  2  00 stop, 01 fence/fence.tso/pause, 10 ecall, 11 ebreak

## Operation
- Reset values: state = LOAD; halt_cause = 00; fetch_valid = 0; fetch_inst = 0; ld_rdata = 0; ld_err = 0; starvation counter = 0. The grant and memory outputs are combinational: fetch_gnt and ld_gnt are 0 until requests arrive, and mem_we is 0 when no loader write is granted.
- LOAD and HALT states:
  - The loader owns the memory. When ld_req = 1, the loader gets ld_gnt = 1 for reads and writes.
  - fetch_gnt is held at 0.
  - start moves the FSM to RUN on the next edge and clears halt_cause.
- RUN state:
  - Fetch has priority: fetch_gnt = fetch_req.
  - A loader read is granted when fetch_req = 0.
  - A loader write is never granted; ld_err pulses for each write-request cycle.
  - Starvation counter: increments on each cycle with an ungranted ld_req read. When it equals STARVE_MAX, the loader is granted that cycle, fetch_gnt = 0, and the counter clears. The counter also clears on any loader grant or when ld_req drops.
  - stop moves the FSM to HALT with cause 00.
  - If start and stop arrive together, stop wins. start is ignored while in RUN, and stop is ignored outside RUN.
- Memory mux:
  - On a fetch grant, mem_addr = fetch_pc[AW+1:2].
  - On a loader grant, mem_addr = ld_addr, mem_we = ld_we, and mem_wdata = ld_wdata.
  - When nothing is granted, mem_we = 0 and mem_addr holds its last value.
- PC handling: fetch_pc bits above AW+1 are ignored, so the address wraps modulo 64 words. fetch_pc[1:0] is ignored.
- Halt detection on the fetched word (mem_rdata at the grant edge):
  - Opcode 0001111 → cause 01.
  - Opcode 1110011 with imm = 0 → cause 10.
  - Opcode 1110011 with imm = 1 → cause 11.
  - On detection, the state goes to HALT. The halting word is still delivered with fetch_valid = 1.
- Reset asserted mid-operation returns to the reset values on the next edge, discarding any pending data.

## Timing
- Fetch latency is 1 cycle. A grant at cycle t gives fetch_inst = mem_rdata and fetch_valid = 1 at t+1.
- With no grant at t, fetch_valid = 0 at t+1.
- fetch_flush at the grant cycle t gives fetch_valid = 0 at t+1 and suppresses halt detection for that word.
- Loader read latency is 1 cycle: ld_rdata is valid the cycle after ld_gnt. A loader write takes effect at the ld_gnt edge.
- A halt detected at cycle t gives state = HALT at t+1, so no fetch grant is possible from t+1 onward.
- The loader may be granted at t+1.
- Back-to-back fetches sustain one word per cycle.

## Configuration
- IMEM_HALT_DETECT_EN defined: opcode-based halt detection is active as described above.
- IMEM_HALT_DETECT_EN undefined:
  - No opcode decode; fence and system words are fetched as ordinary instructions.
  - HALT is reached only via stop, and halt_cause is always 00.

## Structure
- Shared package holds:
  - state encodings LOAD/RUN/HALT
  - halt-cause encodings
  - opcode constants OPC_MISC_MEM = 0001111 and OPC_SYSTEM = 1110011
  - the AW and N defaults
- One sub-module, imem_halt_decode: a combinational instruction → {halt, cause} decoder, instantiated only under IMEM_HALT_DETECT_EN.

## Test plan
- Load then run:
  - After reset, the loader writes 0x00000033 to addr 0 and 0x00002083 to addr 1, then pulses start.
  - Fetch pc=0 then pc=4 → fetch_inst = 0x00000033, then 0x00002083, each valid one cycle after its grant.
- Halt on fence:
  - Memory word 34 = 0x0000000F; fetch pc=0x88.
  - → word delivered with fetch_valid = 1, then state = 10, halt_cause = 01, fetch_gnt = 0 thereafter.
- Ecall vs ebreak: word 0x00000073 → cause 10; word 0x00100073 → cause 11.
- Starvation:
  - In RUN, fetch_req is held high and the loader read of addr 5 is held.
  - → ld_gnt after exactly STARVE_MAX = 8 waiting cycles, fetch_gnt = 0 in that cycle, ld_rdata = mem[5] on the next cycle.
- Write rejection and wrap:
  - A loader write in RUN → ld_err pulses and memory is unchanged.
  - fetch_pc = 0x104 → mem_addr = 1.
- Flush and reset: fetch_flush on the grant of an ecall → fetch_valid = 0 and the state stays RUN; rst low mid-RUN → state = 00 and all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
// State/cause encodings, opcode constants and width defaults.
package imem_fetch_arbiter_pkg;

  localparam int N_DEF      = 32;
  localparam int AW_DEF     = 6;
  localparam int STARVE_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_STOP   = 2'b00,
    CAUSE_FENCE  = 2'b01,
    CAUSE_ECALL  = 2'b10,
    CAUSE_EBREAK = 2'b11
  } cause_t;

  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Fetch, loader and memory-port bundle for the fetch arbiter.
// slave = arbiter view, master = clients/memory view.
interface imem_fetch_arbiter_if
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
);
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_flush;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [N-1:0]  fetch_inst;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_wdata;
  logic          ld_gnt;
  logic [N-1:0]  ld_rdata;
  logic          ld_err;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  modport slave (
    input  fetch_req, fetch_pc, fetch_flush,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_valid, fetch_inst,
    output ld_gnt, ld_rdata, ld_err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_req, fetch_pc, fetch_flush,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_valid, fetch_inst,
    input  ld_gnt, ld_rdata, ld_err,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_fetch_arbiter_halt_decode.sv
// imem_halt_decode: combinational instruction -> {halt, cause}.
// Fence family halts on opcode; ecall/ebreak need funct3 = 0.
module imem_halt_decode
  import imem_fetch_arbiter_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_halt,
  output cause_t      o_cause
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [11:0] w_imm;
  logic        w_sys;
  logic        w_unused;

  assign w_opc    = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_imm    = i_inst[31:20];
  assign w_sys    = (w_opc == OPC_SYSTEM) && (w_f3 == 3'd0);
  assign w_unused = ^{i_inst[19:15], i_inst[11:7]};

  always_comb begin
    o_halt  = 1'b0;
    o_cause = CAUSE_STOP;
    unique case (1'b1)
      (w_opc == OPC_MISC_MEM): begin
        o_halt  = 1'b1;
        o_cause = CAUSE_FENCE;
      end
      (w_sys && w_imm == 12'd0): begin
        o_halt  = 1'b1;
        o_cause = CAUSE_ECALL;
      end
      (w_sys && w_imm == 12'd1): begin
        o_halt  = 1'b1;
        o_cause = CAUSE_EBREAK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Single-port IMEM arbiter: loader/fetch sharing, LOAD/RUN/HALT FSM.
// IMEM_HALT_DETECT_EN enables opcode-based halt on fetched words.
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = STARVE_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  imem_fetch_arbiter_if.slave  bus,
  output logic [1:0]           state,
  output logic [1:0]           halt_cause
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        r_state;
  cause_t        r_cause;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_valid;
  logic          r_ld_err;
  logic [N-1:0]  r_inst;
  logic [N-1:0]  r_rdata;

  logic          w_run;
  logic          w_ld_rd;
  logic          w_starve;
  logic          w_fgnt;
  logic          w_lgnt;
  logic          w_take;
  logic          w_halt;
  cause_t        w_cause;
  logic [AW-1:0] w_pc_word;
  logic [AW-1:0] w_addr;

`ifdef IMEM_HALT_DETECT_EN
  imem_halt_decode u_dec (
    .i_inst  (bus.mem_rdata),
    .o_halt  (w_halt),
    .o_cause (w_cause)
  );
`else
  assign w_halt  = 1'b0;
  assign w_cause = CAUSE_STOP;
`endif

  assign w_run     = (r_state == ST_RUN);
  assign w_ld_rd   = bus.ld_req & ~bus.ld_we;
  assign w_starve  = w_run & w_ld_rd
                   & (r_cnt == CW'(STARVE_MAX));
  assign w_fgnt    = w_run & bus.fetch_req & ~w_starve;
  assign w_lgnt    = bus.ld_req
                   & (~w_run
                   | (w_ld_rd & (~bus.fetch_req | w_starve)));
  assign w_take    = w_fgnt & ~bus.fetch_flush;
  assign w_pc_word = bus.fetch_pc[AW+1:2];

  // Idle cycles keep the previous address on the memory port.
  assign w_addr = w_fgnt ? w_pc_word
                : w_lgnt ? bus.ld_addr
                : r_addr;

  assign bus.fetch_gnt   = w_fgnt;
  assign bus.ld_gnt      = w_lgnt;
  assign bus.fetch_valid = r_valid;
  assign bus.fetch_inst  = r_inst;
  assign bus.ld_rdata    = r_rdata;
  assign bus.ld_err      = r_ld_err;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_we      = w_lgnt & bus.ld_we;
  assign bus.mem_wdata   = w_lgnt ? bus.ld_wdata : '0;
  assign state           = r_state;
  assign halt_cause      = r_cause;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_LOAD;
      r_cause  <= CAUSE_STOP;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_ld_err <= 1'b0;
      r_inst   <= '0;
      r_rdata  <= '0;
    end else begin
      r_addr   <= w_addr;
      r_valid  <= w_take;
      r_ld_err <= w_run & bus.ld_req & bus.ld_we;
      if (w_take)
        r_inst <= bus.mem_rdata;
      if (w_lgnt & ~bus.ld_we)
        r_rdata <= bus.mem_rdata;
      if (w_lgnt | ~bus.ld_req)
        r_cnt <= '0;
      else if (w_ld_rd)
        r_cnt <= r_cnt + CW'(1);
      case (r_state)
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_HALT;
            r_cause <= CAUSE_STOP;
          end else if (w_take & w_halt) begin
            r_state <= ST_HALT;
            r_cause <= w_cause;
          end
        end
        default: begin
          if (start) begin
            r_state <= ST_RUN;
            r_cause <= CAUSE_STOP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a 64-word memory model
// and a scoreboard queue of expected fetched words.
module tb_imem_fetch_arbiter;
  import imem_fetch_arbiter_pkg::*;

`ifdef IMEM_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stop;
  logic [1:0] state;
  logic [1:0] halt_cause;

  imem_fetch_arbiter_if bus ();

  imem_fetch_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .bus        (bus),
    .state      (state),
    .halt_cause (halt_cause)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  logic [31:0] fq [$];
  int total = 0;
  int bad   = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk)
    if (bus.mem_we)
      mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every valid fetched word must match the next queued expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.fetch_valid === 1'b1) begin
      e = (fq.size() != 0) ? fq.pop_front() : 32'hxxxxxxxx;
      chk("fetch_inst", bus.fetch_inst, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [5:0] a,
                          input logic [31:0] d);
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = a;
    bus.ld_wdata = d;
    #1;
    chk("ldw_gnt", bus.ld_gnt, 1);
    chk("ldw_we", bus.mem_we, 1);
    tick();
    bus.ld_req = 1'b0;
    bus.ld_we  = 1'b0;
    shadow[a]  = d;
  endtask

  task automatic ld_read(input logic [5:0] a);
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = a;
    #1;
    chk("ldr_gnt", bus.ld_gnt, 1);
    chk("ldr_addr", bus.mem_addr, a);
    tick();
    bus.ld_req = 1'b0;
    chk("ldr_data", bus.ld_rdata, shadow[a]);
  endtask

  task automatic fetch_cycle(input logic [31:0] pc,
                             input bit fl);
    logic [5:0] w;
    w = pc[7:2];
    bus.fetch_req   = 1'b1;
    bus.fetch_pc    = pc;
    bus.fetch_flush = fl;
    #1;
    chk("f_gnt", bus.fetch_gnt, 1);
    chk("f_addr", bus.mem_addr, w);
    if (!fl)
      fq.push_back(shadow[w]);
    tick();
    bus.fetch_req   = 1'b0;
    bus.fetch_flush = 1'b0;
    chk("f_valid", bus.fetch_valid, fl ? 0 : 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bus.fetch_req = 1'b0;
    bus.fetch_pc = '0;
    bus.fetch_flush = 1'b0;
    bus.ld_req = 1'b0;
    bus.ld_we = 1'b0;
    bus.ld_addr = '0;
    bus.ld_wdata = '0;
    tick();
    tick();

    chk("rst_state", state, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_valid", bus.fetch_valid, 0);
    chk("rst_inst", bus.fetch_inst, 0);
    chk("rst_rdata", bus.ld_rdata, 0);
    chk("rst_err", bus.ld_err, 0);
    chk("rst_fgnt", bus.fetch_gnt, 0);
    chk("rst_lgnt", bus.ld_gnt, 0);
    chk("rst_we", bus.mem_we, 0);
    rst = 1'b1;
    tick();

    // Load phase
    ld_write(6'd0, 32'h0000_0033);
    ld_write(6'd1, 32'h0000_2083);
    ld_write(6'd2, 32'h1234_5678);
    ld_write(6'd5, 32'hDEAD_BEEF);
    ld_write(6'd34, 32'h0000_000F);
    ld_write(6'd40, 32'h0000_0073);
    ld_write(6'd41, 32'h0010_0073);
    chk("load_err", bus.ld_err, 0);
    ld_read(6'd2);

    bus.fetch_req = 1'b1;
    #1;
    chk("load_fgnt", bus.fetch_gnt, 0);
    bus.fetch_req = 1'b0;
    tick();

    pulse_start();
    chk("run_state", state, 1);
    chk("run_cause", halt_cause, 0);

    // Back-to-back fetches
    fetch_cycle(32'h0, 1'b0);
    fetch_cycle(32'h4, 1'b0);
    tick();
    chk("idle_valid", bus.fetch_valid, 0);

    // PC wrap and ignored low bits
    fetch_cycle(32'h0000_0106, 1'b0);
    fetch_cycle(32'hFFFF_FF08, 1'b0);

    // Loader write rejected in RUN
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 6'd0;
    bus.ld_wdata = 32'hFFFF_FFFF;
    #1;
    chk("rej_gnt", bus.ld_gnt, 0);
    chk("rej_we", bus.mem_we, 0);
    tick();
    bus.ld_req = 1'b0;
    bus.ld_we  = 1'b0;
    chk("rej_err", bus.ld_err, 1);
    tick();
    chk("rej_err_end", bus.ld_err, 0);
    chk("rej_mem", mem[0], 32'h0000_0033);
    fetch_cycle(32'h0, 1'b0);

    ld_read(6'd5);

    // Starvation of a loader read behind continuous fetch
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8;
    bus.ld_req    = 1'b1;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 6'd5;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stv_fgnt", bus.fetch_gnt, 1);
      chk("stv_lgnt", bus.ld_gnt, 0);
      fq.push_back(shadow[2]);
      tick();
    end
    #1;
    chk("stv_grant", bus.ld_gnt, 1);
    chk("stv_fblk", bus.fetch_gnt, 0);
    chk("stv_addr", bus.mem_addr, 5);
    tick();
    bus.ld_req    = 1'b0;
    bus.fetch_req = 1'b0;
    chk("stv_rdata", bus.ld_rdata, 32'hDEAD_BEEF);
    chk("stv_valid", bus.fetch_valid, 0);

    // Flushed ecall neither delivers nor halts
    fetch_cycle(32'hA0, 1'b1);
    chk("flush_state", state, 1);

    // Fence
    fetch_cycle(32'h88, 1'b0);
    chk("fence_state", state, HD ? 2 : 1);
    chk("fence_cause", halt_cause, HD ? 1 : 0);
    if (!HD)
      pulse_stop();
    chk("halt_state", state, 2);
    bus.fetch_req = 1'b1;
    bus.ld_req    = 1'b1;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 6'd34;
    #1;
    chk("halt_fgnt", bus.fetch_gnt, 0);
    chk("halt_lgnt", bus.ld_gnt, 1);
    tick();
    bus.fetch_req = 1'b0;
    bus.ld_req    = 1'b0;
    chk("halt_rdata", bus.ld_rdata, 32'h0000_000F);
    chk("halt_valid", bus.fetch_valid, 0);
    pulse_stop();
    chk("stop_in_halt", state, 2);
    pulse_start();
    chk("restart", state, 1);
    chk("restart_cause", halt_cause, 0);

    // Ecall
    fetch_cycle(32'hA0, 1'b0);
    chk("ecall_state", state, HD ? 2 : 1);
    chk("ecall_cause", halt_cause, HD ? 2 : 0);
    if (!HD)
      pulse_stop();
    pulse_start();

    // Ebreak
    fetch_cycle(32'hA4, 1'b0);
    chk("ebrk_state", state, HD ? 2 : 1);
    chk("ebrk_cause", halt_cause, HD ? 3 : 0);
    if (!HD)
      pulse_stop();
    pulse_start();
    chk("ebrk_clear", halt_cause, 0);

    // start ignored in RUN, stop beats start
    pulse_start();
    chk("start_in_run", state, 1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("both_state", state, 2);
    chk("both_cause", halt_cause, 0);
    pulse_start();
    fetch_cycle(32'h4, 1'b0);

    // Reset mid-RUN with fetch and rejected write pending
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h4;
    bus.ld_req    = 1'b1;
    bus.ld_we     = 1'b1;
    bus.ld_addr   = 6'd7;
    rst = 1'b0;
    tick();
    bus.fetch_req = 1'b0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    chk("mrst_state", state, 0);
    chk("mrst_cause", halt_cause, 0);
    chk("mrst_valid", bus.fetch_valid, 0);
    chk("mrst_inst", bus.fetch_inst, 0);
    chk("mrst_rdata", bus.ld_rdata, 0);
    chk("mrst_err", bus.ld_err, 0);
    chk("mrst_mem7", mem[7], 0);
    rst = 1'b1;
    tick();

    chk("fq_empty", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
